// File: rtl/bin_gray_pkg.sv
// Shared constants for the binary/BCD-to-Gray encoder and any block
// that reuses its Gray encoder.
package bin_gray_pkg;

  // Width of the binary input and Gray output words.
  localparam int GRAY_W = 4;

  // Largest value that is still a valid BCD digit.
  localparam logic [GRAY_W-1:0] BCD_MAX = 4'd9;

endpackage : bin_gray_pkg

// File: rtl/bin_gray_gray_enc.sv
// Combinational reflected-binary Gray encoder.
// This is a pure XOR network with no state, so any block that needs a
// binary-to-Gray conversion can instantiate it.
module gray_enc
  import bin_gray_pkg::*;
(
  input  logic [GRAY_W-1:0] bin,
  output logic [GRAY_W-1:0] gray
);

  // The MSB passes through; each lower bit is the XOR of its bit and the bit above it.
  always_comb begin
    gray[3] = bin[3];
    gray[2] = bin[3] ^ bin[2];
    gray[1] = bin[2] ^ bin[1];
    gray[0] = bin[1] ^ bin[0];
  end

endmodule : gray_enc

// File: rtl/bin_gray.sv
// Registered 4-bit binary/BCD-to-Gray encoder.
// The encoder has one cycle of latency. Every output comes straight from a
// flop. G and bcd_err hold their values through idle cycles. out_valid marks
// the cycles in which they carry a new result.
module bin_gray
  import bin_gray_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              A,
  input  logic              B,
  input  logic              C,
  input  logic              D,
  output logic [GRAY_W-1:0] G,
  output logic              out_valid,
  output logic              bcd_err
);

  logic [GRAY_W-1:0] bin;
  logic [GRAY_W-1:0] gray_enc_out;
  logic              err_now;

  logic [GRAY_W-1:0] g_q, g_d;
  logic              err_q, err_d;
  logic              vld_q, vld_d;

  // Gather the four single-bit inputs into one binary word, with A as the LSB.
  assign bin = {D, C, B, A};

  // All 16 codes are encoded. Codes 10-15 are flagged but not clamped.
  gray_enc u_gray_enc (
    .bin  (bin),
    .gray (gray_enc_out)
  );

  // Codes above 9 are not valid BCD digits.
  assign err_now = (bin > BCD_MAX);

  // Next state: load a new result on a valid input. Otherwise hold the data
  // and drop out_valid.
  always_comb begin
    g_d   = g_q;
    err_d = err_q;
    vld_d = 1'b0;
    if (in_valid) begin
      g_d   = gray_enc_out;
      err_d = err_now;
      vld_d = 1'b1;
    end
  end

  // Output register bank. Reset clears it at once, so an in-flight result is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q   <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      g_q   <= g_d;
      err_q <= err_d;
      vld_q <= vld_d;
    end
  end

  assign G         = g_q;
  assign bcd_err   = err_q;
  assign out_valid = vld_q;

endmodule : bin_gray

// File: tb/tb_bin_gray.sv
// Directed table-driven bench for bin_gray, with hand-written reset sequences.
module tb_bin_gray;

  typedef struct {
    logic       vld;
    logic [3:0] bin;
    logic       exp_vld;
    logic [3:0] exp_g;
    logic       exp_err;
  } vec_t;

  localparam int NVEC = 23;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       a, b, c, d;
  logic [3:0] g;
  logic       out_valid;
  logic       bcd_err;

  int n_checks;
  int n_fail;

  vec_t tbl [NVEC];

  bin_gray dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .C         (c),
    .D         (d),
    .G         (g),
    .out_valid (out_valid),
    .bcd_err   (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] bin);
    in_valid = v;
    {d, c, b, a} = bin;
  endtask

  initial begin
    logic [3:0] prev_g;
    n_checks = 0;
    n_fail   = 0;
    prev_g   = 4'b0000;

    // Full sweep. Results appear one cycle after each input.
    tbl[0]  = '{1'b1, 4'd0,  1'b1, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 4'd1,  1'b1, 4'b0001, 1'b0};
    tbl[2]  = '{1'b1, 4'd2,  1'b1, 4'b0011, 1'b0};
    tbl[3]  = '{1'b1, 4'd3,  1'b1, 4'b0010, 1'b0};
    tbl[4]  = '{1'b1, 4'd4,  1'b1, 4'b0110, 1'b0};
    tbl[5]  = '{1'b1, 4'd5,  1'b1, 4'b0111, 1'b0};
    tbl[6]  = '{1'b1, 4'd6,  1'b1, 4'b0101, 1'b0};
    tbl[7]  = '{1'b1, 4'd7,  1'b1, 4'b0100, 1'b0};
    tbl[8]  = '{1'b1, 4'd8,  1'b1, 4'b1100, 1'b0};
    tbl[9]  = '{1'b1, 4'd9,  1'b1, 4'b1101, 1'b0};
    tbl[10] = '{1'b1, 4'd10, 1'b1, 4'b1111, 1'b1};
    tbl[11] = '{1'b1, 4'd11, 1'b1, 4'b1110, 1'b1};
    tbl[12] = '{1'b1, 4'd12, 1'b1, 4'b1010, 1'b1};
    tbl[13] = '{1'b1, 4'd13, 1'b1, 4'b1011, 1'b1};
    tbl[14] = '{1'b1, 4'd14, 1'b1, 4'b1001, 1'b1};
    tbl[15] = '{1'b1, 4'd15, 1'b1, 4'b1000, 1'b1};
    // Gapped valid: the 15 presented while in_valid=0 is ignored.
    tbl[16] = '{1'b1, 4'd5,  1'b1, 4'b0111, 1'b0};
    tbl[17] = '{1'b0, 4'd15, 1'b0, 4'b0111, 1'b0};
    tbl[18] = '{1'b1, 4'd6,  1'b1, 4'b0101, 1'b0};
    // bcd_err holds through an idle cycle.
    tbl[19] = '{1'b1, 4'd10, 1'b1, 4'b1111, 1'b1};
    tbl[20] = '{1'b0, 4'd0,  1'b0, 4'b1111, 1'b1};
    // A 9 clears the flag; the idle cycle that follows holds G and bcd_err.
    tbl[21] = '{1'b1, 4'd9,  1'b1, 4'b1101, 1'b0};
    tbl[22] = '{1'b0, 4'd3,  1'b0, 4'b1101, 1'b0};

    // Reset with every input at 1. The outputs stay cleared.
    rst_n = 1'b0;
    drive(1'b1, 4'b1111);
    #1;
    check("reset_async_G", g, 4'b0000);
    check("reset_async_vld", {3'b0, out_valid}, 4'd0);
    check("reset_async_err", {3'b0, bcd_err}, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_clk_G", g, 4'b0000);
    check("reset_clk_vld", {3'b0, out_valid}, 4'd0);
    check("reset_clk_err", {3'b0, bcd_err}, 4'd0);
    @(negedge clk);
    drive(1'b0, 4'b1111);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_release_G", g, 4'b0000);
    check("post_release_vld", {3'b0, out_valid}, 4'd0);
    check("post_release_err", {3'b0, bcd_err}, 4'd0);

    // Table pass, one transaction per clock.
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].vld, tbl[i].bin);
      @(posedge clk);
      #1;
      $display("txn %0d: vld=%b bin=%0d -> G=%b out_valid=%b bcd_err=%b",
               i, tbl[i].vld, tbl[i].bin, g, out_valid, bcd_err);
      check($sformatf("vec%0d_G", i), g, tbl[i].exp_g);
      check($sformatf("vec%0d_vld", i), {3'b0, out_valid}, {3'b0, tbl[i].exp_vld});
      check($sformatf("vec%0d_err", i), {3'b0, bcd_err}, {3'b0, tbl[i].exp_err});
      if (i >= 1 && i <= 15) begin
        check($sformatf("vec%0d_onebit", i), 4'($countones(g ^ prev_g)), 4'd1);
      end
      prev_g = g;
    end

    // Reset in mid-stream while out_valid=1. It takes effect between clock edges.
    drive(1'b1, 4'd9);
    @(posedge clk);
    #1;
    $display("txn mid: vld=1 bin=9 -> G=%b out_valid=%b bcd_err=%b", g, out_valid, bcd_err);
    check("mid_pre_G", g, 4'b1101);
    check("mid_pre_vld", {3'b0, out_valid}, 4'd1);
    drive(1'b1, 4'd12);
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn rst: async reset -> G=%b out_valid=%b bcd_err=%b", g, out_valid, bcd_err);
    check("mid_rst_G", g, 4'b0000);
    check("mid_rst_vld", {3'b0, out_valid}, 4'd0);
    check("mid_rst_err", {3'b0, bcd_err}, 4'd0);
    drive(1'b0, 4'd12);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("txn rel: idle after release -> G=%b out_valid=%b bcd_err=%b", g, out_valid, bcd_err);
    check("mid_rel_G", g, 4'b0000);
    check("mid_rel_vld", {3'b0, out_valid}, 4'd0);
    check("mid_rel_err", {3'b0, bcd_err}, 4'd0);

    // The first capture after release behaves normally.
    drive(1'b1, 4'd14);
    @(posedge clk);
    #1;
    $display("txn post: vld=1 bin=14 -> G=%b out_valid=%b bcd_err=%b", g, out_valid, bcd_err);
    check("post_G", g, 4'b1001);
    check("post_vld", {3'b0, out_valid}, 4'd1);
    check("post_err", {3'b0, bcd_err}, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bin_gray
